// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_I    = 2'd1;
    localparam owner_t OWN_D    = 2'd2;

endpackage

// File: rtl/sp_ram_bm.sv
// Single-port RAM with a registered 1-cycle read and byte-masked write; a write returns the pre-write word.
// Contents are not preloaded here: INIT_FILE is accepted for interface compatibility with the macro wrapper.
module sp_ram_bm #(
    parameter int AW        = 6,
    parameter int DW        = 32,
    parameter     INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            en,
    input  logic [AW-1:0]   addr,
    input  logic [DW/8-1:0] wmask,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            for (int k = 0; k < DW/8; k++) begin
                if (wmask[k]) mem_q[addr][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch (I) and data (D); D wins unless fetch has waited MAX_WAIT cycles.
// Define MEM_ARB_STATS_EN to build the contention and forced-grant counters.
module mem_port_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = 4,
    parameter     INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    input  logic            i_kill,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_wmask,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic [31:0]     cnt_conf,
    output logic [31:0]     cnt_force
);
    import mem_arb_pkg::*;

    localparam int WW = $clog2(MAX_WAIT + 1);

    owner_t          owner_q, owner_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [DW-1:0]   i_hold_q, d_hold_q;
    logic [DW-1:0]   ram_rdata;
    logic            force_i;

    assign force_i = i_req && (wait_q == WW'(MAX_WAIT));
    assign d_gnt   = !reset && d_req && !force_i;
    assign i_gnt   = !reset && i_req && !d_gnt;

    sp_ram_bm #(.AW(AW), .DW(DW), .INIT_FILE(INIT_FILE)) u_ram (
        .clk   (clk),
        .en    (d_gnt || i_gnt),
        .addr  (d_gnt ? d_addr : i_addr),
        .wmask (d_gnt ? d_wmask : '0),
        .wdata (d_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        owner_d = OWN_NONE;
        if (d_gnt)      owner_d = OWN_D;
        else if (i_gnt) owner_d = OWN_I;
        wait_d = '0;
        if (i_req && !i_gnt) wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            wait_q   <= '0;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            wait_q  <= wait_d;
            if (owner_q == OWN_I) i_hold_q <= ram_rdata;
            if (owner_q == OWN_D) d_hold_q <= ram_rdata;
        end
    end

    // Gating with reset discards a response still in flight when reset arrives.
    assign i_rvalid = !reset && (owner_q == OWN_I) && !i_kill;
    assign d_rvalid = !reset && (owner_q == OWN_D);
    assign i_rdata  = (owner_q == OWN_I) ? ram_rdata : i_hold_q;
    assign d_rdata  = (owner_q == OWN_D) ? ram_rdata : d_hold_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] conf_q, force_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conf_q  <= '0;
            force_q <= '0;
        end else begin
            if (i_req && d_req) conf_q  <= conf_q + 32'd1;
            if (i_gnt && d_req) force_q <= force_q + 32'd1;
        end
    end

    assign cnt_conf  = conf_q;
    assign cnt_force = force_q;
`else
    assign cnt_conf  = '0;
    assign cnt_force = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a word-array reference model.
module tb_mem_port_arbiter;

    localparam int AW = 6, DW = 32, MAX_WAIT = 4, NB = DW/8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_gnt, i_kill, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [NB-1:0] d_wmask;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [31:0]   cnt_conf, cnt_force;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] ref_mem [2**AW];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_kill(i_kill),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .cnt_conf(cnt_conf), .cnt_force(cnt_force)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NB-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < NB; k++) if (m[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        return r;
    endfunction

    task automatic idle();
        i_req = 0; i_kill = 0; d_req = 0; d_wmask = '0;
    endtask

    task automatic gap();
        idle();
        @(posedge clk); #1;
    endtask

    task automatic d_write(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [DW-1:0] v);
        d_req = 1; d_addr = a; d_wmask = m; d_wdata = v;
        @(posedge clk); #1;
        d_req = 0; d_wmask = '0;
        ref_mem[a] = merge(ref_mem[a], v, m);
    endtask

    task automatic pulse_reset();
        idle(); reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; i_req = 1; d_req = 1; i_addr = '0; d_addr = '0; d_wmask = '0; d_wdata = '0; i_kill = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                n_bad++; $display("FAIL reset_gnt: i_gnt=%b d_gnt=%b required 0 0", i_gnt, d_gnt);
            end
        end
        @(posedge clk); #1;
        reset = 0; idle();
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL reset_rvalid: i=%b d=%b required 0 0", i_rvalid, d_rvalid);
        end
        n_cmp++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_bad++; $display("FAIL reset_rdata: i=%h d=%h required 0 0", i_rdata, d_rdata);
        end
        n_cmp++;
        if (cnt_conf !== 32'd0 || cnt_force !== 32'd0) begin
            n_bad++; $display("FAIL reset_cnt: conf=%0d force=%0d required 0 0", cnt_conf, cnt_force);
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_mem();
        for (int w = 0; w < 2**AW; w++) d_write(AW'(w), '1, $urandom);
        gap();
    endtask

    task automatic test_fetch_basic();
        d_write(AW'(3), '1, 32'hDEADBEEF);
        gap();
        i_req = 1; i_addr = AW'(3);
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            n_bad++; $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b required 1 0", i_gnt, d_gnt);
        end
        @(posedge clk); #1;
        i_req = 0;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL fetch_resp: rvalid=%b rdata=%h d_rvalid=%b required 1 deadbeef 0",
                              i_rvalid, i_rdata, d_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        d_write(AW'(5), '1, 32'h11223344);
        gap();
        d_req = 1; d_addr = AW'(5); d_wmask = 4'b0010; d_wdata = 32'h0000AB00;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL store_gnt: d_gnt=%b required 1", d_gnt); end
        @(posedge clk); #1;
        idle();
        ref_mem[5] = merge(ref_mem[5], 32'h0000AB00, 4'b0010);
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h11223344) begin
            n_bad++; $display("FAIL store_ack: rvalid=%b rdata=%h required 1 11223344", d_rvalid, d_rdata);
        end
        @(posedge clk); #1;
        d_req = 1; d_addr = AW'(5); d_wmask = '0;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122AB44) begin
            n_bad++; $display("FAIL store_readback: rvalid=%b rdata=%h required 1 1122ab44", d_rvalid, d_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic [5:0] pat_i;
        logic [31:0] exp_conf, exp_force;
        pat_i = 6'b010000;
        pulse_reset();
        i_req = 1; d_req = 1; i_addr = AW'(1); d_addr = AW'(2); d_wmask = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (i_gnt !== pat_i[c] || d_gnt !== !pat_i[c]) begin
                n_bad++; $display("FAIL contention_gnt c=%0d: i_gnt=%b d_gnt=%b required %b %b",
                                  c, i_gnt, d_gnt, pat_i[c], !pat_i[c]);
            end
            @(posedge clk); #1;
        end
        idle();
`ifdef MEM_ARB_STATS_EN
        exp_conf = 32'd6; exp_force = 32'd1;
`else
        exp_conf = 32'd0; exp_force = 32'd0;
`endif
        @(negedge clk);
        n_cmp++;
        if (cnt_conf !== exp_conf || cnt_force !== exp_force) begin
            n_bad++; $display("FAIL contention_cnt: conf=%0d force=%0d required %0d %0d",
                              cnt_conf, cnt_force, exp_conf, exp_force);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        gap();
        i_req = 1; i_addr = AW'(3);
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1) begin n_bad++; $display("FAIL kill_gnt0: i_gnt=%b required 1", i_gnt); end
        @(posedge clk); #1;
        i_addr = AW'(4); i_kill = 1;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b0 || i_gnt !== 1'b1) begin
            n_bad++; $display("FAIL kill_drop: i_rvalid=%b i_gnt=%b required 0 1", i_rvalid, i_gnt);
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[4]) begin
            n_bad++; $display("FAIL kill_next: i_rvalid=%b i_rdata=%h required 1 %h", i_rvalid, i_rdata, ref_mem[4]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [4:0] pat_i;
        pat_i = 5'b10000;
        gap();
        i_req = 1; d_req = 1; i_addr = AW'(20); d_addr = AW'(10); d_wmask = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre c=%0d: d_gnt=%b required 1", c, d_gnt); end
            @(posedge clk); #1;
        end
        reset = 1; d_wmask = '1; d_wdata = ~ref_mem[10];
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_hold: d_rvalid=%b i_rvalid=%b d_gnt=%b i_gnt=%b required 0 0 0 0",
                              d_rvalid, i_rvalid, d_gnt, i_gnt);
        end
        @(posedge clk); #1;
        reset = 0; d_wmask = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
                    n_bad++; $display("FAIL rstmid_after: d_rvalid=%b i_rvalid=%b required 0 0", d_rvalid, i_rvalid);
                end
            end
            n_cmp++;
            if (i_gnt !== pat_i[c] || d_gnt !== !pat_i[c]) begin
                n_bad++; $display("FAIL rstmid_wait c=%0d: i_gnt=%b d_gnt=%b required %b %b",
                                  c, i_gnt, d_gnt, pat_i[c], !pat_i[c]);
            end
            @(posedge clk); #1;
        end
        gap();
        d_req = 1; d_addr = AW'(10); d_wmask = '0;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[10]) begin
            n_bad++; $display("FAIL rstmid_ram: d_rvalid=%b d_rdata=%h required 1 %h", d_rvalid, d_rdata, ref_mem[10]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [4];
        logic ed;
        a[0] = AW'(0); a[1] = AW'(1); a[2] = AW'(2); a[3] = AW'(7);
        gap();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 3) begin d_req = 1; d_addr = a[k]; end
            else if (k == 3) begin i_req = 1; i_addr = a[k]; end
            @(negedge clk);
            if (k < 4) begin
                n_cmp++;
                if (d_gnt !== (k < 3) || i_gnt !== (k == 3)) begin
                    n_bad++; $display("FAIL b2b_gnt k=%0d: d_gnt=%b i_gnt=%b", k, d_gnt, i_gnt);
                end
            end
            if (k > 0) begin
                ed = (k - 1 < 3);
                n_cmp++;
                if (d_rvalid !== ed || i_rvalid !== !ed) begin
                    n_bad++; $display("FAIL b2b_valid k=%0d: d_rvalid=%b i_rvalid=%b required %b %b",
                                      k, d_rvalid, i_rvalid, ed, !ed);
                end
                n_cmp++;
                if ((ed ? d_rdata : i_rdata) !== ref_mem[a[k-1]]) begin
                    n_bad++; $display("FAIL b2b_data k=%0d: got %h required %h",
                                      k, ed ? d_rdata : i_rdata, ref_mem[a[k-1]]);
                end
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_random();
        int streak, conf_e, force_e;
        logic [1:0] prev;
        logic [DW-1:0] prev_data, last_i, last_d;
        logic ig, dg, exp_i, exp_d, exp_iv, exp_dv;
        gap();
        pulse_reset();
        streak = 0; conf_e = 0; force_e = 0; prev = 2'd0; prev_data = '0;
        last_i = '0; last_d = '0; ig = 0; dg = 0;
        for (int c = 0; c < 400; c++) begin
            if (i_req && !ig) begin
                if ($urandom_range(7) == 0) i_req = 0;
            end else begin
                i_req = 1'($urandom_range(1)); i_addr = AW'($urandom);
            end
            if (d_req && !dg) begin
                if ($urandom_range(7) == 0) d_req = 0;
            end else begin
                d_req = 1'($urandom_range(1)); d_addr = AW'($urandom); d_wdata = $urandom;
                d_wmask = ($urandom_range(1) == 1) ? NB'($urandom) : '0;
            end
            i_kill = ($urandom_range(3) == 0);
            @(negedge clk);
            exp_d = d_req && !(i_req && streak >= MAX_WAIT);
            exp_i = i_req && !exp_d;
            n_cmp++;
            if (i_gnt !== exp_i || d_gnt !== exp_d) begin
                n_bad++; $display("FAIL rnd_gnt c=%0d: i_gnt=%b d_gnt=%b required %b %b", c, i_gnt, d_gnt, exp_i, exp_d);
            end
            exp_iv = (prev == 2'd1) && !i_kill;
            exp_dv = (prev == 2'd2);
            if (prev == 2'd1) last_i = prev_data;
            if (prev == 2'd2) last_d = prev_data;
            n_cmp++;
            if (i_rvalid !== exp_iv || d_rvalid !== exp_dv) begin
                n_bad++; $display("FAIL rnd_valid c=%0d: i_rvalid=%b d_rvalid=%b required %b %b",
                                  c, i_rvalid, d_rvalid, exp_iv, exp_dv);
            end
            n_cmp++;
            if (i_rdata !== last_i || d_rdata !== last_d) begin
                n_bad++; $display("FAIL rnd_data c=%0d: i_rdata=%h d_rdata=%h required %h %h",
                                  c, i_rdata, d_rdata, last_i, last_d);
            end
            if (i_req && d_req) conf_e++;
            if (exp_i && d_req) force_e++;
            streak = (i_req && !exp_i) ? streak + 1 : 0;
            prev = exp_d ? 2'd2 : (exp_i ? 2'd1 : 2'd0);
            prev_data = exp_d ? ref_mem[d_addr] : ref_mem[i_addr];
            if (exp_d) ref_mem[d_addr] = merge(ref_mem[d_addr], d_wdata, d_wmask);
            ig = exp_i; dg = exp_d;
            @(posedge clk); #1;
        end
        idle();
`ifndef MEM_ARB_STATS_EN
        conf_e = 0; force_e = 0;
`endif
        @(negedge clk);
        n_cmp++;
        if (cnt_conf !== 32'(conf_e) || cnt_force !== 32'(force_e)) begin
            n_bad++; $display("FAIL rnd_cnt: conf=%0d force=%0d required %0d %0d", cnt_conf, cnt_force, conf_e, force_e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; i_req = 0; i_kill = 0; i_addr = '0; d_req = 0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        test_reset();
        fill_mem();
        test_fetch_basic();
        test_store();
        test_contention();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
